// File: rtl/lift_dispatch_pkg.sv
// Shared types and helpers for the hall-call dispatcher.
//   disp_state_t  : dispatcher FSM states
//   DIR_UP/DIR_DN : direction encoding used on every direction signal
//   dispatch_cost : distance cost plus a one-building-height penalty for a lift
//                   that is moving away from the call or travelling the other way
package lift_dispatch_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, ISSUE} disp_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int unsigned dispatch_cost(input int unsigned call_floor,
                                                input int unsigned lift_floor,
                                                input logic        moving,
                                                input logic        lift_dir,
                                                input logic        call_dir,
                                                input int unsigned n_floors);
    int unsigned cost;
    logic        away;
    cost = (call_floor > lift_floor) ? call_floor - lift_floor : lift_floor - call_floor;
    away = (lift_dir == DIR_UP) ? (lift_floor > call_floor) : (lift_floor < call_floor);
    if (moving && (away || (lift_dir != call_dir))) begin
      cost = cost + n_floors;
    end
    return cost;
  endfunction

endpackage

// File: rtl/dispatch_cost_unit.sv
// Combinational cost of serving one call with one lift.
//   call_floor/call_dir : call under evaluation
//   lift_*              : state of the lift being evaluated this cycle
//   cost                : FW+1 bit cost (distance, plus N_FLOORS penalty)
//   eligible            : lift accepts hall calls
module dispatch_cost_unit
  import lift_dispatch_pkg::*;
#(
  parameter int unsigned N_FLOORS = 12,
  parameter int unsigned FW       = $clog2(N_FLOORS)
) (
  input  logic [FW-1:0] call_floor,
  input  logic          call_dir,
  input  logic [FW-1:0] lift_floor,
  input  logic          lift_dir,
  input  logic          lift_motion,
  input  logic          lift_avail,
  output logic [FW:0]   cost,
  output logic          eligible
);

  int unsigned raw_cost;

  always_comb begin
    raw_cost = dispatch_cost(32'(call_floor), 32'(lift_floor), lift_motion, lift_dir,
                             call_dir, N_FLOORS);
    // Max cost is 2*N_FLOORS-1, which always fits in FW+1 bits.
    cost     = raw_cost[FW:0];
    eligible = lift_avail;
  end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Latches hall calls and assigns each pending call to one lift.
//   clk, reset (async, active low)
//   hall_up/hall_dn      : call requests per floor
//   lift_floor/dir/motion/avail : per-lift state, lift i floor at [i*FW +: FW]
//   srv_valid/floor/dir  : service report, clears the matching call
//   asg_valid/ready, asg_lift/floor/dir : assignment handshake
//   pend_up/pend_dn      : latched calls, assigned or not
module hall_call_dispatcher
  import lift_dispatch_pkg::*;
#(
  parameter  int unsigned N_FLOORS = 12,
  parameter  int unsigned N_LIFTS  = 10,
  localparam int unsigned FW       = $clog2(N_FLOORS),
  localparam int unsigned LW       = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_FLOORS-1:0]   hall_up,
  input  logic [N_FLOORS-1:0]   hall_dn,
  input  logic [N_LIFTS*FW-1:0] lift_floor,
  input  logic [N_LIFTS-1:0]    lift_dir,
  input  logic [N_LIFTS-1:0]    lift_motion,
  input  logic [N_LIFTS-1:0]    lift_avail,
  input  logic                  srv_valid,
  input  logic [FW-1:0]         srv_floor,
  input  logic                  srv_dir,
  output logic                  asg_valid,
  input  logic                  asg_ready,
  output logic [LW-1:0]         asg_lift,
  output logic [FW-1:0]         asg_floor,
  output logic                  asg_dir,
  output logic [N_FLOORS-1:0]   pend_up,
  output logic [N_FLOORS-1:0]   pend_dn
);

  // Scan index space: up calls 0..N_FLOORS-1, then down calls.
  localparam int unsigned NC = 2 * N_FLOORS;
  localparam int unsigned IW = $clog2(NC);
  // No up call from the top floor, no down call from the bottom floor.
  localparam logic [N_FLOORS-1:0] UP_OK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_OK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  disp_state_t         state_q;
  logic [LW-1:0]       k_q, best_lift_q, asg_lift_q;
  logic [FW:0]         best_cost_q;
  logic                any_elig_q, call_dir_q, asg_valid_q, asg_dir_q;
  logic [IW-1:0]       call_idx_q, ptr_q;
  logic [FW-1:0]       call_floor_q, asg_floor_q;
  logic [N_FLOORS-1:0] pend_up_q, pend_dn_q, asg_up_q, asg_dn_q;
  logic [N_FLOORS-1:0] pend_up_d, pend_dn_d, asg_up_d, asg_dn_d;
  logic [N_FLOORS-1:0] clr_up, clr_dn, set_up, set_dn;

  logic [NC-1:0] pend_all, cand;
  logic          cand_found, cand_dir;
  logic [IW-1:0] cand_idx, ptr_next;
  logic [FW-1:0] cand_floor;
  int            j;

  logic          hs, call_gone, last, take;
  logic [FW:0]   cur_cost;
  logic          cur_elig;

  assign pend_all = {pend_dn_q, pend_up_q};
  assign cand     = pend_all & ~{asg_dn_q, asg_up_q};

  // First candidate at or after the scan pointer, wrapping.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    j          = 0;
    for (int i = 0; i < int'(NC); i++) begin
      j = int'(ptr_q) + i;
      if (j >= int'(NC)) j = j - int'(NC);
      if (!cand_found && cand[j]) begin
        cand_found = 1'b1;
        cand_idx   = IW'(j);
      end
    end
    if (int'(cand_idx) < int'(N_FLOORS)) begin
      cand_floor = FW'(cand_idx);
      cand_dir   = DIR_UP;
    end else begin
      cand_floor = FW'(int'(cand_idx) - int'(N_FLOORS));
      cand_dir   = DIR_DN;
    end
  end

  always_comb begin
    clr_up = '0;
    clr_dn = '0;
    set_up = '0;
    set_dn = '0;
    hs     = (state_q == ISSUE) && asg_ready;
    if (srv_valid && (int'(srv_floor) < int'(N_FLOORS))) begin
      if (srv_dir == DIR_UP) clr_up[srv_floor] = 1'b1;
      else                   clr_dn[srv_floor] = 1'b1;
    end
    if (hs) begin
      if (call_dir_q == DIR_UP) set_up[call_floor_q] = 1'b1;
      else                      set_dn[call_floor_q] = 1'b1;
    end
    // Clear beats a new request or assignment on the same bit.
    pend_up_d = (pend_up_q | (hall_up & UP_OK)) & ~clr_up;
    pend_dn_d = (pend_dn_q | (hall_dn & DN_OK)) & ~clr_dn;
    asg_up_d  = (asg_up_q | set_up) & ~clr_up;
    asg_dn_d  = (asg_dn_q | set_dn) & ~clr_dn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_up_q <= '0;
      pend_dn_q <= '0;
      asg_up_q  <= '0;
      asg_dn_q  <= '0;
    end else begin
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
      asg_up_q  <= asg_up_d;
      asg_dn_q  <= asg_dn_d;
    end
  end

  // One cost unit shared across lifts, lift k_q evaluated each EVAL cycle.
  dispatch_cost_unit #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_cost (
    .call_floor  (call_floor_q),
    .call_dir    (call_dir_q),
    .lift_floor  (lift_floor[int'(k_q)*FW +: FW]),
    .lift_dir    (lift_dir[k_q]),
    .lift_motion (lift_motion[k_q]),
    .lift_avail  (lift_avail[k_q]),
    .cost        (cur_cost),
    .eligible    (cur_elig)
  );

  // The held call is dropped if serviced now or already cleared under us.
  assign call_gone = (srv_valid && (srv_floor == call_floor_q) && (srv_dir == call_dir_q)) ||
                     !pend_all[call_idx_q];
  assign last      = (k_q == LW'(N_LIFTS - 1));
  // First eligible lift always taken so a cost equal to the sentinel still wins.
  assign take      = cur_elig && (!any_elig_q || (cur_cost < best_cost_q));
  assign ptr_next  = (call_idx_q == IW'(NC - 1)) ? '0 : call_idx_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      best_cost_q  <= '0;
      best_lift_q  <= '0;
      any_elig_q   <= 1'b0;
      call_idx_q   <= '0;
      call_floor_q <= '0;
      call_dir_q   <= 1'b0;
      ptr_q        <= '0;
      asg_valid_q  <= 1'b0;
      asg_lift_q   <= '0;
      asg_floor_q  <= '0;
      asg_dir_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cand_found) begin
            state_q      <= EVAL;
            k_q          <= '0;
            best_cost_q  <= '1;
            best_lift_q  <= '0;
            any_elig_q   <= 1'b0;
            call_idx_q   <= cand_idx;
            call_floor_q <= cand_floor;
            call_dir_q   <= cand_dir;
          end
        end
        EVAL: begin
          if (call_gone) begin
            state_q <= IDLE;
          end else begin
            k_q        <= k_q + 1'b1;
            any_elig_q <= any_elig_q | cur_elig;
            if (take) begin
              best_cost_q <= cur_cost;
              best_lift_q <= k_q;
            end
            if (last) begin
              if (any_elig_q || cur_elig) begin
                state_q     <= ISSUE;
                asg_valid_q <= 1'b1;
                asg_lift_q  <= take ? k_q : best_lift_q;
                asg_floor_q <= call_floor_q;
                asg_dir_q   <= call_dir_q;
              end else begin
                state_q <= IDLE;
                ptr_q   <= ptr_next;
              end
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            state_q     <= IDLE;
            asg_valid_q <= 1'b0;
            ptr_q       <= ptr_next;
          end else if (call_gone) begin
            state_q     <= IDLE;
            asg_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign asg_valid = asg_valid_q;
  assign asg_lift  = asg_lift_q;
  assign asg_floor = asg_floor_q;
  assign asg_dir   = asg_dir_q;
  assign pend_up   = pend_up_q;
  assign pend_dn   = pend_dn_q;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
module tb_hall_call_dispatcher;

  localparam int NF = 12;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] hall_up, hall_dn;
  logic [15:0]   lift_floor;
  logic [NL-1:0] lift_dir, lift_motion, lift_avail;
  logic          srv_valid, srv_dir;
  logic [3:0]    srv_floor;
  logic          asg_valid, asg_ready, asg_dir;
  logic [1:0]    asg_lift;
  logic [3:0]    asg_floor;
  logic [NF-1:0] pend_up, pend_dn;

  always #5 clk = ~clk;

  hall_call_dispatcher #(
    .N_FLOORS (NF),
    .N_LIFTS  (NL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hall_up     (hall_up),
    .hall_dn     (hall_dn),
    .lift_floor  (lift_floor),
    .lift_dir    (lift_dir),
    .lift_motion (lift_motion),
    .lift_avail  (lift_avail),
    .srv_valid   (srv_valid),
    .srv_floor   (srv_floor),
    .srv_dir     (srv_dir),
    .asg_valid   (asg_valid),
    .asg_ready   (asg_ready),
    .asg_lift    (asg_lift),
    .asg_floor   (asg_floor),
    .asg_dir     (asg_dir),
    .pend_up     (pend_up),
    .pend_dn     (pend_dn)
  );

  typedef struct packed {
    logic [15:0] fl;
    logic [3:0]  mv;
    logic [3:0]  dr;
    logic [3:0]  av;
    logic [3:0]  cf;
    logic        cd;
    logic [1:0]  el;
  } vec_t;

  typedef struct packed {
    logic [1:0] lift;
    logic [3:0] floor;
    logic       dir;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  localparam logic [15:0] IDLE_FL = {4'd11, 4'd7, 4'd3, 4'd0};

  function automatic vec_t mkvec(logic [15:0] fl, logic [3:0] mv, logic [3:0] dr,
                                 logic [3:0] av, int cf, logic cd, int el);
    vec_t v;
    v.fl = fl; v.mv = mv; v.dr = dr; v.av = av;
    v.cf = 4'(cf); v.cd = cd; v.el = 2'(el);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic set_lifts(input vec_t v);
    lift_floor  = v.fl;
    lift_motion = v.mv;
    lift_dir    = v.dr;
    lift_avail  = v.av;
  endtask

  function automatic int pend_bit(input int f, input logic d);
    return d ? int'(pend_up[f]) : int'(pend_dn[f]);
  endfunction

  task automatic pulse(input int f, input logic d);
    if (d) hall_up[f] = 1'b1;
    else   hall_dn[f] = 1'b1;
    step();
    hall_up = '0;
    hall_dn = '0;
  endtask

  // Waits (bounded) for an offer, pops the scoreboard and compares.
  // lat_exp != 0 checks cycles counted from the pulse edge.
  task automatic expect_asg(input int budget, input int lat_exp);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (asg_valid !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    check("asg_valid_arrives", int'(asg_valid), 1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    check("asg_lift", int'(asg_lift), int'(e.lift));
    check("asg_floor", int'(asg_floor), int'(e.floor));
    check("asg_dir", int'(asg_dir), int'(e.dir));
    if (lat_exp != 0) check("latency", cyc + 1, lat_exp);
  endtask

  task automatic handshake();
    asg_ready = 1'b1;
    step();
    asg_ready = 1'b0;
    check("valid_drops_after_hs", int'(asg_valid), 0);
  endtask

  task automatic service(input int f, input logic d);
    srv_valid = 1'b1;
    srv_floor = 4'(f);
    srv_dir   = d;
    step();
    srv_valid = 1'b0;
  endtask

  task automatic run_call(input int f, input logic d, input int lift);
    sb.push_back({2'(lift), 4'(f), d});
    pulse(f, d);
    expect_asg(30, NL + 2);
    handshake();
    check("pend_held_until_srv", pend_bit(f, d), 1);
    service(f, d);
    check("pend_cleared_by_srv", pend_bit(f, d), 0);
  endtask

  task automatic no_offer(input string name, input int n);
    int saw;
    saw = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (asg_valid) saw = 1;
    end
    check(name, saw, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_asg_valid"}, int'(asg_valid), 0);
    check({tag, "_asg_lift"}, int'(asg_lift), 0);
    check({tag, "_asg_floor"}, int'(asg_floor), 0);
    check({tag, "_asg_dir"}, int'(asg_dir), 0);
    check({tag, "_pend_up"}, int'(pend_up), 0);
    check({tag, "_pend_dn"}, int'(pend_dn), 0);
  endtask

  initial begin
    reset = 1'b0;
    hall_up = '0; hall_dn = '0;
    lift_floor = IDLE_FL; lift_dir = '0; lift_motion = '0; lift_avail = '1;
    srv_valid = 1'b0; srv_floor = '0; srv_dir = 1'b0;
    asg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    step();

    // Requests that cannot exist are never latched.
    hall_dn[0]  = 1'b1;
    hall_up[11] = 1'b1;
    step();
    hall_up = '0; hall_dn = '0;
    check("ignored_up_top", int'(pend_up), 0);
    check("ignored_dn_bottom", int'(pend_dn), 0);
    no_offer("ignored_no_offer", 10);

    //                 floors (l3..l0)              moving   dir      avail   cf  cd   lift
    vecs[0] = mkvec(IDLE_FL,                        4'b0000, 4'b0000, 4'b1111, 5, 1'b1, 1);
    vecs[1] = mkvec({4'd11, 4'd4, 4'd4, 4'd9},      4'b0000, 4'b0000, 4'b1111, 4, 1'b0, 1);
    vecs[2] = mkvec({4'd0, 4'd11, 4'd6, 4'd2},      4'b0011, 4'b0001, 4'b1111, 4, 1'b1, 0);
    vecs[3] = mkvec({4'd3, 4'd0, 4'd9, 4'd5},       4'b0101, 4'b0101, 4'b0111, 3, 1'b1, 2);
    vecs[4] = mkvec({4'd6, 4'd10, 4'd8, 4'd0},      4'b0110, 4'b0010, 4'b1111, 11, 1'b0, 3);
    vecs[5] = mkvec({4'd7, 4'd2, 4'd3, 4'd1},       4'b0001, 4'b0000, 4'b1011, 0, 1'b1, 1);
    vecs[6] = mkvec({4'd11, 4'd0, 4'd0, 4'd0},      4'b0000, 4'b0000, 4'b1000, 1, 1'b0, 3);
    for (int i = 0; i < 7; i++) begin
      set_lifts(vecs[i]);
      run_call(int'(vecs[i].cf), vecs[i].cd, int'(vecs[i].el));
    end

    // No lift available: call stays pending, then served once a lift frees up.
    set_lifts(mkvec(IDLE_FL, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 0));
    pulse(3, 1'b1);
    no_offer("unavail_no_offer", 20);
    check("unavail_pend_kept", pend_bit(3, 1'b1), 1);
    lift_avail = 4'b0100;
    sb.push_back({2'd2, 4'd3, 1'b1});
    expect_asg(40, 0);
    handshake();
    service(3, 1'b1);
    check("unavail_pend_cleared", pend_bit(3, 1'b1), 0);

    // Stalled consumer: offer held steady, then withdrawn when the call is serviced.
    set_lifts(mkvec(IDLE_FL, 4'b0000, 4'b0000, 4'b1111, 0, 1'b0, 0));
    sb.push_back({2'd2, 4'd6, 1'b0});
    pulse(6, 1'b0);
    expect_asg(30, NL + 2);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", int'(asg_valid), 1);
      check("stall_lift", int'(asg_lift), 2);
      check("stall_floor", int'(asg_floor), 6);
      check("stall_dir", int'(asg_dir), 0);
    end
    service(6, 1'b0);
    check("drop_valid_low", int'(asg_valid), 0);
    check("drop_pend_cleared", pend_bit(6, 1'b0), 0);
    no_offer("drop_no_reoffer", 10);
    // Dropped call must not have been marked assigned: a new request is dispatched.
    run_call(6, 1'b0, 2);

    // Pointer wrap: after dn[11] the scan restarts at up[0], so up[2] precedes dn[8].
    run_call(11, 1'b0, 3);
    sb.push_back({2'd1, 4'd2, 1'b1});
    sb.push_back({2'd2, 4'd8, 1'b0});
    hall_up[2] = 1'b1;
    hall_dn[8] = 1'b1;
    step();
    hall_up = '0; hall_dn = '0;
    expect_asg(30, NL + 2);
    handshake();
    expect_asg(30, 0);
    handshake();
    service(2, 1'b1);
    service(8, 1'b0);
    check("pair_pend_up_clear", int'(pend_up), 0);
    check("pair_pend_dn_clear", int'(pend_dn), 0);

    // Reset in the middle of evaluation.
    pulse(5, 1'b1);
    step();
    step();
    check("midreset_pend_before", pend_bit(5, 1'b1), 1);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    no_offer("midreset_no_offer", 10);
    check("midreset_pend_lost", int'(pend_up), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
